// File: rtl/instruction_fetch_unit_pkg.sv
// Purpose: shared widths, depth and fetch-state encodings for the instruction fetch unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package instruction_fetch_unit_pkg;
  localparam int IMEM_ADDR_W = 4;
  localparam int IMEM_DEPTH  = 15;
  localparam int INSTR_W     = 32;

  // Encoding 3 is unused; the FSM recovers from it to FS_IDLE.
  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_DONE  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Purpose: program counter register, priority load > increment > hold.
// Latency: new value visible one cycle after load_en/inc_en.
// Backpressure: none; the caller gates inc_en.
// Ports: clk, reset (async active-high), load_en/load_val, inc_en, pc.
module instruction_fetch_unit_pc_register #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc_en,
  output logic [ADDR_W-1:0] pc
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (load_en) begin
      pc <= load_val;
    end else if (inc_en) begin
      pc <= pc + 1'b1;
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Purpose: owns the PC, reads the combinational instruction memory and registers each word into IF/ID.
// Latency: pc presented in cycle N -> if_valid in cycle N+1; one word per cycle at full throughput.
// Backpressure: if_valid && !if_ready holds pc, if_instr and if_pc; redirect flushes even while stalled.
// Ports: clk, reset, start | imem_addr, imem_read_en, imem_instr | redirect_en, redirect_pc |
//        if_valid, if_ready, if_instr, if_pc | busy, done.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int DATA_W    = INSTR_W,
  parameter int MEM_DEPTH = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_read_en,
  input  logic [DATA_W-1:0] imem_instr,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_DEPTH - 1);
  // One extra bit so a depth of 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(MEM_DEPTH);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              load;
  logic              at_last;
  logic              redirect_ok;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic              pc_inc;

  assign load        = (state == FS_FETCH) && (!if_valid || if_ready);
  assign at_last     = (pc == LAST_PC);
  assign redirect_ok = ({1'b0, redirect_pc} < DEPTH_X);

  assign imem_addr    = pc;
  assign imem_read_en = (state == FS_FETCH);
  assign busy         = (state == FS_FETCH);
  assign done         = (state == FS_DONE);

  // PC control; an out-of-range redirect leaves pc where it is.
  always_comb begin
    pc_load     = 1'b0;
    pc_load_val = '0;
    pc_inc      = 1'b0;
    case (state)
      FS_IDLE: begin
        if (start) pc_load = 1'b1;
      end
      FS_FETCH: begin
        if (redirect_en) begin
          if (redirect_ok) begin
            pc_load     = 1'b1;
            pc_load_val = redirect_pc;
          end
        end else if (load && !at_last) begin
          pc_inc = 1'b1;
        end
      end
      FS_DONE: begin
        if (redirect_en) begin
          if (redirect_ok) begin
            pc_load     = 1'b1;
            pc_load_val = redirect_pc;
          end
        end else if (start) begin
          pc_load = 1'b1;
        end
      end
      default: pc_load = 1'b1;
    endcase
  end

  instruction_fetch_unit_pc_register #(.ADDR_W(ADDR_W)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load_en  (pc_load),
    .load_val (pc_load_val),
    .inc_en   (pc_inc),
    .pc       (pc)
  );

  // Fetch FSM and IF/ID output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FS_IDLE;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      case (state)
        FS_IDLE: begin
          if_valid <= 1'b0;
          if (start) state <= FS_FETCH;
        end
        FS_FETCH: begin
          if (redirect_en) begin
            // Flush wins over load: a word accepted this cycle still transfers.
            if_valid <= 1'b0;
            state    <= redirect_ok ? FS_FETCH : FS_DONE;
          end else if (load) begin
            if_valid <= 1'b1;
            if_instr <= imem_instr;
            if_pc    <= pc;
            if (at_last) state <= FS_DONE;
          end
        end
        FS_DONE: begin
          if (redirect_en) begin
            if_valid <= 1'b0;
            state    <= redirect_ok ? FS_FETCH : FS_DONE;
          end else if (start) begin
            // Restart drops any last word still waiting for decode.
            if_valid <= 1'b0;
            state    <= FS_FETCH;
          end else if (if_valid && if_ready) begin
            if_valid <= 1'b0;
          end
        end
        default: begin
          state    <= FS_IDLE;
          if_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  imem_addr;
  logic        imem_read_en;
  logic [31:0] imem_instr;
  logic        redirect_en;
  logic [3:0]  redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [3:0]  if_pc;
  logic        busy;
  logic        done;

  logic [31:0] imem [0:15];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imem_instr = imem[imem_addr];

  instruction_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .imem_addr    (imem_addr),
    .imem_read_en (imem_read_en),
    .imem_instr   (imem_instr),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " if_valid"},     32'(if_valid),     32'd0);
    chk({tag, " if_instr"},     if_instr,          32'd0);
    chk({tag, " if_pc"},        32'(if_pc),        32'd0);
    chk({tag, " imem_addr"},    32'(imem_addr),    32'd0);
    chk({tag, " imem_read_en"}, 32'(imem_read_en), 32'd0);
    chk({tag, " busy"},         32'(busy),         32'd0);
    chk({tag, " done"},         32'(done),         32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) imem[i] = 32'h0;
    imem[0] = 32'h018D4820;
    imem[1] = 32'h01CE5020;
    imem[2] = 32'h01494022;

    reset = 1'b1; start = 1'b0; redirect_en = 1'b0; redirect_pc = 4'd0; if_ready = 1'b0;
    cyc(); cyc();
    chk_all_zero("reset");
    reset = 1'b0;

    // Redirect in IDLE is ignored.
    redirect_en = 1'b1; redirect_pc = 4'd5;
    cyc();
    chk("idle_redir busy", 32'(busy), 32'd0);
    chk("idle_redir addr", 32'(imem_addr), 32'd0);
    redirect_en = 1'b0;

    // Full sweep at full throughput, stopping at the last word without wrapping.
    if_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start busy", 32'(busy), 32'd1);
    chk("start read_en", 32'(imem_read_en), 32'd1);
    chk("start addr", 32'(imem_addr), 32'd0);
    chk("start if_valid", 32'(if_valid), 32'd0);
    for (int i = 0; i < 15; i++) begin
      cyc();
      chk($sformatf("sweep%0d valid", i), 32'(if_valid), 32'd1);
      chk($sformatf("sweep%0d pc", i), 32'(if_pc), 32'(i));
      chk($sformatf("sweep%0d instr", i), if_instr, imem[i]);
    end
    chk("last done", 32'(done), 32'd1);
    chk("last busy", 32'(busy), 32'd0);
    chk("last read_en", 32'(imem_read_en), 32'd0);
    chk("last addr", 32'(imem_addr), 32'd14);
    cyc();
    chk("after_last valid", 32'(if_valid), 32'd0);
    chk("after_last addr", 32'(imem_addr), 32'd14);
    chk("after_last done", 32'(done), 32'd1);

    // Restart from DONE, then stall on the first word; start while busy is ignored.
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart addr", 32'(imem_addr), 32'd0);
    chk("restart busy", 32'(busy), 32'd1);
    cyc();
    chk("w0 pc", 32'(if_pc), 32'd0);
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      cyc();
      chk($sformatf("stall%0d valid", i), 32'(if_valid), 32'd1);
      chk($sformatf("stall%0d instr", i), if_instr, 32'h018D4820);
      chk($sformatf("stall%0d pc", i), 32'(if_pc), 32'd0);
      chk($sformatf("stall%0d addr", i), 32'(imem_addr), 32'd1);
    end
    start = 1'b0;
    if_ready = 1'b1;
    cyc();
    chk("release pc", 32'(if_pc), 32'd1);
    chk("release instr", if_instr, 32'h01CE5020);

    // Redirect back to 0, stall there, then redirect to 2 while stalled.
    redirect_en = 1'b1; redirect_pc = 4'd0;
    cyc();
    chk("redir0 valid", 32'(if_valid), 32'd0);
    redirect_en = 1'b0; if_ready = 1'b0;
    cyc();
    chk("redir0 word pc", 32'(if_pc), 32'd0);
    chk("redir0 word instr", if_instr, 32'h018D4820);
    cyc();
    chk("redir0 stall valid", 32'(if_valid), 32'd1);
    redirect_en = 1'b1; redirect_pc = 4'd2;
    cyc();
    chk("redir2 flush valid", 32'(if_valid), 32'd0);
    chk("redir2 addr", 32'(imem_addr), 32'd2);
    redirect_en = 1'b0; if_ready = 1'b1;
    cyc();
    chk("redir2 valid", 32'(if_valid), 32'd1);
    chk("redir2 pc", 32'(if_pc), 32'd2);
    chk("redir2 instr", if_instr, 32'h01494022);
    cyc();
    chk("redir2 next pc", 32'(if_pc), 32'd3);
    chk("redir2 next instr", if_instr, 32'h0);

    // Out-of-range redirect parks in DONE with pc held.
    redirect_en = 1'b1; redirect_pc = 4'd15;
    cyc();
    redirect_en = 1'b0;
    chk("oor done", 32'(done), 32'd1);
    chk("oor valid", 32'(if_valid), 32'd0);
    chk("oor read_en", 32'(imem_read_en), 32'd0);
    chk("oor addr", 32'(imem_addr), 32'd4);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("oor restart pc", 32'(if_pc), 32'd0);
    chk("oor restart instr", if_instr, 32'h018D4820);

    // Async reset in the middle of a stall clears everything without a clock edge.
    if_ready = 1'b0;
    cyc();
    chk("pre_rst valid", 32'(if_valid), 32'd1);
    #2 reset = 1'b1;
    #1 chk_all_zero("async_rst");
    cyc();
    reset = 1'b0; if_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("post_rst pc", 32'(if_pc), 32'd0);
    chk("post_rst instr", if_instr, 32'h018D4820);
    chk("post_rst valid", 32'(if_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
